pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It detects load-use hazards that forwarding cannot cover and injects ID/EX bubbles. It flushes IF/ID on taken branches, runs the data-memory request/acknowledge handshake, and freezes the whole pipeline while memory is busy. It also times out hung accesses into a sticky error state and counts stall cycles.

## Interface
Parameters:
- MEM_TIMEOUT, 16: MEM_WAIT cycles without ack before error; legal 2..255.

Ports (clock and reset first):
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- IFIDRs_i  in  5  rs of instruction in ID.
- IFIDRt_i  in  5  rt of instruction in ID.
- IDEXMemRead_i  in  1  instruction in EX is a load.
- IDEXRt_i  in  5  load destination in EX.
- BranchTaken_i  in  1  branch resolved taken in ID.
- EXMEMMemAccess_i  in  1  instruction in MEM does a load/store.
- DMemAck_i  in  1  data memory completes access this cycle.
- DMemReq_o  out  1  data memory request, level.
- PCWrite_o  out  1  PC update enable.
- IFIDWrite_o  out  1  IF/ID register enable.
- IFIDFlush_o  out  1  zero IF/ID.
- IDEXFlush_o  out  1  zero ID/EX control (bubble).
- PipeFreeze_o  out  1  hold ID/EX and EX/MEM.
- MEMWBBubble_o  out  1  zero MEM/WB control.
- MemError_o  out  1  sticky timeout flag.
- StallCycles_o  out  16  saturating stall-cycle count.

## Operation
- FSM states: RUN, MEM_WAIT, MEM_ERR. Reset state is RUN.
- Internal signals:
  - memstall = EXMEMMemAccess_i & ~DMemAck_i, in RUN or MEM_WAIT.
  - loaduse = IDEXMemRead_i & (IDEXRt_i != 0) & (IDEXRt_i == IFIDRs_i | IDEXRt_i == IFIDRt_i).
- DMemReq_o = EXMEMMemAccess_i in RUN/MEM_WAIT. It is 0 in MEM_ERR.
- Priority is memstall > loaduse > branch:
  - memstall: PCWrite_o=0, IFIDWrite_o=0, PipeFreeze_o=1, MEMWBBubble_o=1. IFIDFlush_o=0 and IDEXFlush_o=0, so loaduse and BranchTaken_i are ignored that cycle.
  - loaduse, no memstall: PCWrite_o=0, IFIDWrite_o=0, IDEXFlush_o=1. IFIDFlush_o=0, because the branch is re-evaluated next cycle.
  - BranchTaken_i only: IFIDFlush_o=1, PCWrite_o=1.
  - Otherwise: PCWrite_o=1, IFIDWrite_o=1, all flush/freeze outputs 0.
- Transitions:
  - RUN→MEM_WAIT on memstall.
  - MEM_WAIT→RUN on DMemAck_i. Freeze drops in that same cycle.
  - MEM_WAIT→MEM_ERR when the wait counter reaches MEM_TIMEOUT-1 without ack.
  - MEM_ERR is left only by reset.
- Wait counter (8 bits) is cleared on entry to MEM_WAIT and increments each MEM_WAIT cycle.
- MEM_ERR outputs: MemError_o=1, PCWrite_o=0, IFIDWrite_o=0, PipeFreeze_o=1, MEMWBBubble_o=1, DMemReq_o=0.
- StallCycles_o increments by 1 on each RUN/MEM_WAIT cycle with PCWrite_o=0. It holds at 16'hFFFF and does not count in MEM_ERR.

## Timing
- Control outputs are combinational from state and inputs, with zero latency.
- State, wait counter, MemError_o and StallCycles_o are registered on posedge clk_i.
- While rst_i=1, regardless of inputs:
  - 0: DMemReq_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXFlush_o, PipeFreeze_o, MEMWBBubble_o, MemError_o, StallCycles_o.
  - State is RUN and the wait counter is 0.
- Reset asserted mid-MEM_WAIT or in MEM_ERR returns to RUN immediately; the pending request is dropped.
- Zero-wait memory (ack in the same cycle as the request) causes no stall and no state change.
- Handshake: DMemReq_o stays high until the cycle DMemAck_i=1. DMemAck_i without a request is ignored.
- Load-use stall lasts exactly 1 cycle; the bubble advances the load to MEM, so loaduse clears.
- Timeout: MEM_ERR is entered on the edge after MEM_WAIT cycle MEM_TIMEOUT-1 counted from 0 (MEM_TIMEOUT cycles of MEM_WAIT).

## Structure
- Shared package pipeline_pkg holds:
  - state encoding constants ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_MEM_ERR=2'd2;
  - STALL_CNT_W=16 and REG_ADDR_W=5.
- One combinational sub-module, load_use_detect: the loaduse compare.
- FSM, counters and priority muxing live in the top module.

## Test plan
- Load-use: IDEXMemRead_i=1, IDEXRt_i=5, IFIDRs_i=5 → one cycle of PCWrite_o=0, IFIDWrite_o=0, IDEXFlush_o=1; StallCycles_o=1.
- IDEXRt_i=0 with IFIDRs_i=0 and IDEXMemRead_i=1 → no stall.
- Branch: BranchTaken_i=1 with no hazard → IFIDFlush_o=1, PCWrite_o=1. Same with loaduse=1 → IDEXFlush_o=1, IFIDFlush_o=0.
- Memory wait:
  - EXMEMMemAccess_i=1, ack after 3 cycles → DMemReq_o high 4 cycles, PipeFreeze_o=1 and MEMWBBubble_o=1 for 3 cycles, StallCycles_o=3.
  - Ack in the same cycle → no freeze.
- Timeout: MEM_TIMEOUT=4, never ack → MEM_ERR after 4 MEM_WAIT cycles, MemError_o=1, DMemReq_o=0, counter frozen. Asserting rst_i mid-error clears all outputs asynchronously.
- Saturation: force more than 65535 stall cycles → StallCycles_o holds 16'hFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and widths for the 5-stage pipeline control logic.
package pipeline_pkg;

  localparam int unsigned STALL_CNT_W = 16;
  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned WAIT_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MEM_ERR  = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination feeds a source of the instruction in ID.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  load_use_c
);

  // r0 is hardwired zero, so a load into it never creates a dependency
  always_comb begin
    load_use_c = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, branch flushes, data-memory
// handshake with pipeline freeze, sticky timeout error and stall counting.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [REG_ADDR_W-1:0]  IFIDRs_i,
  input  logic [REG_ADDR_W-1:0]  IFIDRt_i,
  input  logic                   IDEXMemRead_i,
  input  logic [REG_ADDR_W-1:0]  IDEXRt_i,
  input  logic                   BranchTaken_i,
  input  logic                   EXMEMMemAccess_i,
  input  logic                   DMemAck_i,
  output logic                   DMemReq_o,
  output logic                   PCWrite_o,
  output logic                   IFIDWrite_o,
  output logic                   IFIDFlush_o,
  output logic                   IDEXFlush_o,
  output logic                   PipeFreeze_o,
  output logic                   MEMWBBubble_o,
  output logic                   MemError_o,
  output logic [STALL_CNT_W-1:0] StallCycles_o
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  hazard_state_t          state_q, state_d;
  logic [WAIT_CNT_W-1:0]  wait_q;
  logic                   mem_err_q;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   load_use_c;
  logic                   mem_stall_c;

  load_use_detect u_load_use_detect (
    .ex_mem_read (IDEXMemRead_i),
    .ex_rt       (IDEXRt_i),
    .id_rs       (IFIDRs_i),
    .id_rt       (IFIDRt_i),
    .load_use_c  (load_use_c)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      mem_err_q <= (state_d == ST_MEM_ERR);
      // counter sits at zero outside MEM_WAIT, so it is clear on every entry
      if (state_q == ST_MEM_WAIT) wait_q <= wait_q + WAIT_CNT_W'(1);
      else                        wait_q <= '0;
      if ((state_q != ST_MEM_ERR) && !PCWrite_o && (stall_q != '1))
        stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  // Next state and priority-muxed control: memstall > loaduse > branch
  always_comb begin
    state_d       = state_q;
    mem_stall_c   = 1'b0;
    DMemReq_o     = 1'b0;
    PCWrite_o     = 1'b0;
    IFIDWrite_o   = 1'b0;
    IFIDFlush_o   = 1'b0;
    IDEXFlush_o   = 1'b0;
    PipeFreeze_o  = 1'b0;
    MEMWBBubble_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          DMemReq_o   = EXMEMMemAccess_i;
          mem_stall_c = EXMEMMemAccess_i && !DMemAck_i;
          if (mem_stall_c) begin
            PipeFreeze_o  = 1'b1;
            MEMWBBubble_o = 1'b1;
          end else if (load_use_c) begin
            IDEXFlush_o = 1'b1;
          end else if (BranchTaken_i) begin
            IFIDFlush_o = 1'b1;
            PCWrite_o   = 1'b1;
            IFIDWrite_o = 1'b1;
          end else begin
            PCWrite_o   = 1'b1;
            IFIDWrite_o = 1'b1;
          end
          if (state_q == ST_RUN) begin
            if (mem_stall_c) state_d = ST_MEM_WAIT;
          end else if (!mem_stall_c) begin
            state_d = ST_RUN;
          end else if (wait_q == WAIT_LAST) begin
            state_d = ST_MEM_ERR;
          end
        end
        ST_MEM_ERR: begin
          PipeFreeze_o  = 1'b1;
          MEMWBBubble_o = 1'b1;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign MemError_o    = mem_err_q;
  assign StallCycles_o = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  ifid_rs, ifid_rt, idex_rt;
  logic        idex_mem_read, branch_taken, exmem_access, dmem_ack;
  logic        dmem_req, pc_write, ifid_write, ifid_flush, idex_flush;
  logic        pipe_freeze, memwb_bubble, mem_error;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .IFIDRs_i         (ifid_rs),
    .IFIDRt_i         (ifid_rt),
    .IDEXMemRead_i    (idex_mem_read),
    .IDEXRt_i         (idex_rt),
    .BranchTaken_i    (branch_taken),
    .EXMEMMemAccess_i (exmem_access),
    .DMemAck_i        (dmem_ack),
    .DMemReq_o        (dmem_req),
    .PCWrite_o        (pc_write),
    .IFIDWrite_o      (ifid_write),
    .IFIDFlush_o      (ifid_flush),
    .IDEXFlush_o      (idex_flush),
    .PipeFreeze_o     (pipe_freeze),
    .MEMWBBubble_o    (memwb_bubble),
    .MemError_o       (mem_error),
    .StallCycles_o    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
    idex_mem_read = 1'b0; branch_taken = 1'b0;
    exmem_access = 1'b0; dmem_ack = 1'b0;
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exmem_access = 1'b1; branch_taken = 1'b1;
    idex_mem_read = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    repeat (2) tick();
    total++;
    if ({dmem_req, pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze, memwb_bubble, mem_error} !== 8'h00) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=00000000", {dmem_req, pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze, memwb_bubble, mem_error});
    end
    total++;
    if (stall_cycles !== 16'd0) begin
      bad++;
      $display("FAIL reset_stall got=%0d exp=0", stall_cycles);
    end
    clear_inputs();
    rst = 1'b0;
    tick();
    total++;
    if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_run got=%b%b exp=11", pc_write, ifid_write);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    idex_mem_read = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd9;
    #1;
    total++;
    if ({pc_write, ifid_write, idex_flush, pipe_freeze, ifid_flush} !== 5'b00100) begin
      bad++;
      $display("FAIL load_use_rs got=%b exp=00100", {pc_write, ifid_write, idex_flush, pipe_freeze, ifid_flush});
    end
    tick();
    idex_mem_read = 1'b0;
    #1;
    total++;
    if ({pc_write, ifid_write, idex_flush} !== 3'b110) begin
      bad++;
      $display("FAIL load_use_release got=%b exp=110", {pc_write, ifid_write, idex_flush});
    end
    total++;
    if (stall_cycles !== 16'd1) begin
      bad++;
      $display("FAIL load_use_stall_count got=%0d exp=1", stall_cycles);
    end
    idex_mem_read = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7;
    #1;
    total++;
    if (idex_flush !== 1'b1 || pc_write !== 1'b0) begin
      bad++;
      $display("FAIL load_use_rt got=%b%b exp=10", idex_flush, pc_write);
    end
    clear_inputs();
  endtask

  task automatic test_no_hazard();
    idex_mem_read = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    #1;
    total++;
    if ({pc_write, ifid_write, idex_flush} !== 3'b110) begin
      bad++;
      $display("FAIL r0_no_stall got=%b exp=110", {pc_write, ifid_write, idex_flush});
    end
    idex_rt = 5'd5; ifid_rs = 5'd3; ifid_rt = 5'd4;
    #1;
    total++;
    if ({pc_write, ifid_write, idex_flush} !== 3'b110) begin
      bad++;
      $display("FAIL no_match_no_stall got=%b exp=110", {pc_write, ifid_write, idex_flush});
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    branch_taken = 1'b1;
    #1;
    total++;
    if ({ifid_flush, pc_write, idex_flush} !== 3'b110) begin
      bad++;
      $display("FAIL branch_flush got=%b exp=110", {ifid_flush, pc_write, idex_flush});
    end
    idex_mem_read = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    #1;
    total++;
    if ({ifid_flush, pc_write, idex_flush} !== 3'b001) begin
      bad++;
      $display("FAIL branch_vs_load_use got=%b exp=001", {ifid_flush, pc_write, idex_flush});
    end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    int req_cycles;
    int frz_cycles;
    do_reset();
    req_cycles = 0;
    frz_cycles = 0;
    exmem_access = 1'b1;
    branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1;
      if (dmem_req === 1'b1) req_cycles++;
      if (pipe_freeze === 1'b1 && memwb_bubble === 1'b1) frz_cycles++;
      total++;
      if (i < 3 && {pipe_freeze, memwb_bubble, pc_write, ifid_write, ifid_flush} !== 5'b11000) begin
        bad++;
        $display("FAIL mem_wait_freeze cyc=%0d got=%b exp=11000", i, {pipe_freeze, memwb_bubble, pc_write, ifid_write, ifid_flush});
      end else if (i == 3 && {pipe_freeze, memwb_bubble, pc_write, ifid_flush} !== 4'b0011) begin
        bad++;
        $display("FAIL mem_wait_ack_release got=%b exp=0011", {pipe_freeze, memwb_bubble, pc_write, ifid_flush});
      end
      tick();
    end
    total++;
    if (req_cycles != 4 || frz_cycles != 3) begin
      bad++;
      $display("FAIL mem_wait_lengths req=%0d frz=%0d exp req=4 frz=3", req_cycles, frz_cycles);
    end
    total++;
    if (stall_cycles !== 16'd3) begin
      bad++;
      $display("FAIL mem_wait_stall_count got=%0d exp=3", stall_cycles);
    end
    branch_taken = 1'b0;
    // zero-wait access: ack alongside request, and back-to-back
    exmem_access = 1'b1; dmem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if ({dmem_req, pipe_freeze, pc_write} !== 3'b101) begin
        bad++;
        $display("FAIL zero_wait cyc=%0d got=%b exp=101", i, {dmem_req, pipe_freeze, pc_write});
      end
      tick();
    end
    exmem_access = 1'b0; dmem_ack = 1'b1;
    #1;
    total++;
    if ({dmem_req, pipe_freeze, pc_write} !== 3'b001 || stall_cycles !== 16'd3) begin
      bad++;
      $display("FAIL stray_ack got=%b stall=%0d exp=001 stall=3", {dmem_req, pipe_freeze, pc_write}, stall_cycles);
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    idex_mem_read = 1'b1; idex_rt = 5'd2; ifid_rt = 5'd2;
    repeat (65540) @(posedge clk);
    #1;
    total++;
    if (stall_cycles !== 16'hFFFF) begin
      bad++;
      $display("FAIL stall_saturate got=%h exp=ffff", stall_cycles);
    end
    repeat (3) tick();
    total++;
    if (stall_cycles !== 16'hFFFF) begin
      bad++;
      $display("FAIL stall_hold got=%h exp=ffff", stall_cycles);
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    exmem_access = 1'b1;
    repeat (4) tick();
    total++;
    if ({mem_error, dmem_req, pipe_freeze} !== 3'b011) begin
      bad++;
      $display("FAIL timeout_last_wait got=%b exp=011", {mem_error, dmem_req, pipe_freeze});
    end
    tick();
    total++;
    if ({mem_error, dmem_req, pipe_freeze, memwb_bubble, pc_write, ifid_write} !== 6'b101100) begin
      bad++;
      $display("FAIL timeout_err got=%b exp=101100", {mem_error, dmem_req, pipe_freeze, memwb_bubble, pc_write, ifid_write});
    end
    total++;
    if (stall_cycles !== 16'd5) begin
      bad++;
      $display("FAIL timeout_stall_count got=%0d exp=5", stall_cycles);
    end
    dmem_ack = 1'b1;
    repeat (3) tick();
    total++;
    if (mem_error !== 1'b1 || stall_cycles !== 16'd5 || dmem_req !== 1'b0) begin
      bad++;
      $display("FAIL err_sticky err=%b stall=%0d req=%b exp err=1 stall=5 req=0", mem_error, stall_cycles, dmem_req);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({dmem_req, pipe_freeze, memwb_bubble, mem_error, pc_write} !== 5'b00000 || stall_cycles !== 16'd0) begin
      bad++;
      $display("FAIL reset_in_err got=%b stall=%0d exp=00000 stall=0", {dmem_req, pipe_freeze, memwb_bubble, mem_error, pc_write}, stall_cycles);
    end
    #1;
    rst = 1'b0;
    clear_inputs();
    tick();
    total++;
    if ({mem_error, pc_write, pipe_freeze} !== 3'b010) begin
      bad++;
      $display("FAIL run_after_reset got=%b exp=010", {mem_error, pc_write, pipe_freeze});
    end
    // reset mid-MEM_WAIT drops the pending request
    exmem_access = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exmem_access = 1'b1; dmem_ack = 1'b1;
    #1;
    total++;
    if ({dmem_req, pipe_freeze, pc_write, mem_error} !== 4'b1010) begin
      bad++;
      $display("FAIL reset_in_wait got=%b exp=1010", {dmem_req, pipe_freeze, pc_write, mem_error});
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_mem_wait();
    test_saturation();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
